// File: rtl/addsub_pkg.sv
// Shared constants and FSM encoding for the nibble-serial add/sub arbiter.
package addsub_pkg;
  localparam int NIB      = 4;
  localparam int REQ_ID_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_add4.sv
// 4-bit ripple-carry adder slice; operand inversion for subtract is done by the caller.
module nibble_add4
  import addsub_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout
);
  logic [NIB:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIB; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NIB];
endmodule

// File: rtl/addsub_seq_arbiter.sv
// Two-requester round-robin front end for a shared nibble-serial add/sub datapath.
module addsub_seq_arbiter
  import addsub_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [NIB*WORDS-1:0] req0_a,
  input  logic [NIB*WORDS-1:0] req0_b,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [NIB*WORDS-1:0] req1_a,
  input  logic [NIB*WORDS-1:0] req1_b,
  input  logic                 req1_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REQ_ID_W-1:0]  rsp_id,
  output logic [NIB*WORDS-1:0] rsp_result,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic                 busy
);
  localparam int W     = NIB * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t             state, state_nxt;
  logic               last;
  logic               grant;
  logic               accept;
  logic [IDX_W-1:0]   idx;
  logic               last_nib;
  logic [W-1:0]       a_q, b_q, s_q, s_nxt;
  logic               sub_q, carry_q;
  logic [REQ_ID_W-1:0] id_q;
  logic [NIB-1:0]     b_nib, nib_sum;
  logic               nib_cout;

  // Tie goes to the requester that was not served last.
  assign grant    = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign last_nib = (idx == IDX_W'(WORDS - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: if (rst_n && (req0_valid || req1_valid)) begin
        accept     = 1'b1;
        req0_ready = ~grant;
        req1_ready = grant;
        state_nxt  = RUN;
      end
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Inverting B per nibble with carry-in = sub gives A + ~B + 1 across the whole word.
  assign b_nib = b_q[NIB-1:0] ^ {NIB{sub_q}};

  nibble_add4 u_add (
    .a    (a_q[NIB-1:0]),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // Sum nibbles enter at the top and shift down, so the word is aligned after the last one.
  if (WORDS > 1) begin : g_multi
    assign s_nxt = {nib_sum, s_q[W-1:NIB]};
  end else begin : g_single
    assign s_nxt = nib_sum;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= grant ? req1_a : req0_a;
      b_q     <= grant ? req1_b : req0_b;
      sub_q   <= grant ? req1_sub : req0_sub;
      carry_q <= grant ? req1_sub : req0_sub;
      id_q    <= REQ_ID_W'(grant);
    end else if (state == RUN) begin
      a_q     <= a_q >> NIB;
      b_q     <= b_q >> NIB;
      carry_q <= nib_cout;
      s_q     <= s_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      last       <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_id     <= '0;
    end else begin
      if (accept)              idx <= '0;
      else if (state == RUN)   idx <= idx + 1'b1;
      if (state == RUN && last_nib) begin
        rsp_valid  <= 1'b1;
        rsp_result <= s_nxt;
        rsp_cout   <= nib_cout;
        rsp_ovf    <= (a_q[NIB-1] == b_nib[NIB-1]) & (nib_sum[NIB-1] != a_q[NIB-1]);
        rsp_id     <= id_q;
      end else if (state == DONE && rsp_ready) begin
        rsp_valid  <= 1'b0;
        last       <= rsp_id[0];
      end
    end
  end
endmodule

// File: tb/tb_addsub_seq_arbiter.sv
// Self-checking bench: directed vector table, scripted corner cases, and randomized traffic vs. an arithmetic model.
module tb_addsub_seq_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic        req1_valid, req1_ready, req1_sub;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_ovf, busy;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_result;

  addsub_seq_arbiter #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] r;
    logic        c, o;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] r;
    logic        c, o;
  } rsp_t;

  int          checks = 0, failures = 0;
  int          cyc = 0, acc_cyc = 0;
  logic        vld [2];
  logic [15:0] opa [2], opb [2];
  logic        ops [2];
  logic        outst, last_srv, exp_id, exp_c, exp_o;
  logic [15:0] exp_r;
  rsp_t        rq[$];
  logic        gq[$];
  vec_t        tbl[6];
  logic        rr_pat [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole 16-bit word.
  function automatic void model(input logic [15:0] a, b, input logic s,
                                output logic [15:0] r, output logic c, output logic o);
    int sr;
    if (s) begin
      r  = a - b;
      c  = (a >= b);
      sr = int'($signed(a)) - int'($signed(b));
    end else begin
      {c, r} = {1'b0, a} + {1'b0, b};
      sr = int'($signed(a)) + int'($signed(b));
    end
    o = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic drive();
    req0_valid = vld[0]; req0_a = opa[0]; req0_b = opb[0]; req0_sub = ops[0];
    req1_valid = vld[1]; req1_a = opa[1]; req1_b = opb[1]; req1_sub = ops[1];
  endtask

  // One iteration per clock: pv = % chance to raise a new request, pr = % rsp_ready, pw = % withdraw while waiting.
  task automatic traffic(input int ncyc, input int pv, input int pr, input int pw);
    logic any, g, due, hs;
    for (int t = 0; t < ncyc; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!vld[r] && int'($urandom_range(99)) < pv) begin
          vld[r] = 1'b1;
          opa[r] = 16'($urandom);
          opb[r] = 16'($urandom);
          ops[r] = 1'($urandom_range(1));
        end else if (vld[r] && outst && int'($urandom_range(99)) < pw) begin
          vld[r] = 1'b0;
        end
      end
      drive();
      rsp_ready = (int'($urandom_range(99)) < pr);
      #1;
      any = !outst && (vld[0] || vld[1]);
      g   = (vld[0] && vld[1]) ? ~last_srv : vld[1];
      due = outst && (cyc >= acc_cyc + 5);
      chk("req0_ready", req0_ready, any && !g);
      chk("req1_ready", req1_ready, any && g);
      chk("busy", busy, outst);
      chk("rsp_valid", rsp_valid, due);
      if (due && rsp_valid) begin
        chk("rsp_result", rsp_result, exp_r);
        chk("rsp_cout", rsp_cout, exp_c);
        chk("rsp_ovf", rsp_ovf, exp_o);
        chk("rsp_id", rsp_id, exp_id);
      end
      hs = due && rsp_ready;
      if (hs) rq.push_back('{rsp_id[0], rsp_result, rsp_cout, rsp_ovf});
      @(posedge clk); #1;
      if (any) begin
        outst   = 1'b1;
        acc_cyc = cyc;
        exp_id  = g;
        model(opa[g], opb[g], ops[g], exp_r, exp_c, exp_o);
        vld[g]  = 1'b0;
        gq.push_back(g);
      end
      if (hs) begin
        outst    = 1'b0;
        last_srv = exp_id;
      end
      cyc++;
    end
  endtask

  task automatic do_reset();
    vld[0] = 1'b0; vld[1] = 1'b0;
    drive();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_result", rsp_result, 16'h0);
    chk("rst_rsp_cout", rsp_cout, 1'b0);
    chk("rst_rsp_ovf", rsp_ovf, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive();
    outst = 1'b0; last_srv = 1'b1;
    cyc++;
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h0008, 16'h0010, 1'b1, 16'hFFF8, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h0010, 16'h0008, 1'b1, 16'h0008, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    rr_pat = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int r = 0; r < 2; r++) begin
      vld[r] = 1'b0; opa[r] = '0; opb[r] = '0; ops[r] = 1'b0;
    end
    outst = 1'b0; last_srv = 1'b1; exp_id = 1'b0; exp_r = '0; exp_c = 1'b0; exp_o = 1'b0;
    rst_n = 1'b1; rsp_ready = 1'b0;
    drive();
    #2;
    do_reset();

    // Directed vectors, one requester at a time, 4-cycle latency checked inside traffic.
    for (int i = 0; i < 6; i++) begin
      rq.delete();
      vld[tbl[i].id] = 1'b1; opa[tbl[i].id] = tbl[i].a;
      opb[tbl[i].id] = tbl[i].b; ops[tbl[i].id] = tbl[i].sub;
      traffic(8, 0, 100, 0);
      chk("tbl_rsp_count", rq.size(), 1);
      if (rq.size() > 0) begin
        chk($sformatf("tbl%0d_result", i), rq[0].r, tbl[i].r);
        chk($sformatf("tbl%0d_cout", i), rq[0].c, tbl[i].c);
        chk($sformatf("tbl%0d_ovf", i), rq[0].o, tbl[i].o);
        chk($sformatf("tbl%0d_id", i), rq[0].id, tbl[i].id);
      end
    end

    // Both requesters always valid from reset: alternate 0,1,0,1 at 6 cycles per op.
    do_reset();
    gq.delete();
    traffic(24, 100, 100, 0);
    chk("rr_grant_count", gq.size(), 4);
    if (gq.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), gq[i], rr_pat[i]);
    traffic(30, 0, 100, 0);

    // Consumer stalls in DONE while the other requester waits, then one handshake releases it.
    vld[0] = 1'b1; opa[0] = 16'h1234; opb[0] = 16'h0FFF; ops[0] = 1'b0;
    vld[1] = 1'b1; opa[1] = 16'h8000; opb[1] = 16'h0001; ops[1] = 1'b1;
    traffic(16, 0, 0, 0);
    traffic(16, 0, 100, 0);

    traffic(600, 40, 60, 5);
    traffic(30, 0, 100, 0);

    // Reset in the middle of RUN, then both requesters valid.
    traffic(3, 100, 100, 0);
    do_reset();
    gq.delete();
    traffic(8, 100, 100, 0);
    chk("post_rst_grant_count", gq.size() >= 1, 1'b1);
    if (gq.size() >= 1) chk("post_rst_first_grant", gq[0], 1'b0);
    traffic(30, 0, 100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
